// File: rtl/cpu2_control_unit.sv
// cpu2_control_unit: instruction sequencer for the register_and_alu datapath.
// Accepts 16-bit instructions over a valid/ready handshake and emits one
// registered 14-bit control word per clock. SWAP expands into three words
// that route through the scratch register TMP_REG.
// Optional feature macro: ILLEGAL_TRAP_EN. When defined, illegal opcodes and
// SWAPs that name TMP_REG raise error and halt. When undefined, illegal
// opcodes behave as NOP and error is tied low.
module cpu2_control_unit #(
  parameter logic [2:0] TMP_REG = 3'd7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [13:0] control,
  output logic        halted,
  output logic        error,
  output logic [7:0]  retired
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SW1    = 2'd1,
    SW2    = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [4:0] ALU_PASS_IN = 5'd0;
  localparam logic [4:0] ALU_PASS_A  = 5'd1;
  localparam logic [4:0] ALU_ADD     = 5'd2;
  localparam logic [4:0] ALU_SUB     = 5'd3;
  localparam logic [4:0] ALU_AND     = 5'd4;
  localparam logic [4:0] ALU_OR      = 5'd5;
  localparam logic [4:0] ALU_XOR     = 5'd6;

  state_t      state_q, state_d;
  logic [13:0] control_q, control_d;
  logic        halted_q, halted_d;
  logic [7:0]  retired_q, retired_d;
  logic [2:0]  swap_rd_q, swap_rd_d;
  logic [2:0]  swap_ra_q, swap_ra_d;

  logic [3:0] opc;
  logic [2:0] rd, ra, rb;
  logic       accept;
  logic       trap;
  logic       unused_rsvd;

  assign opc         = instr[15:12];
  assign rd          = instr[11:9];
  assign ra          = instr[8:6];
  assign rb          = instr[5:3];
  assign unused_rsvd = ^instr[2:0];

  assign instr_ready = (state_q == IDLE);
  assign accept      = instr_valid && instr_ready;

`ifdef ILLEGAL_TRAP_EN
  assign trap = accept &&
                (((opc >= 4'h9) && (opc <= 4'hE)) ||
                 ((opc == 4'h8) && ((rd == TMP_REG) || (ra == TMP_REG))));
`else
  assign trap = 1'b0;
`endif

  // Next-state, next control word and retire count for the sequencer.
  always_comb begin
    state_d   = state_q;
    control_d = 14'd0;
    halted_d  = halted_q;
    retired_d = retired_q;
    swap_rd_d = swap_rd_q;
    swap_ra_d = swap_ra_q;
    unique case (state_q)
      IDLE: begin
        if (trap) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end else if (accept) begin
          case (opc)
            4'h0: retired_d = retired_q + 8'd1;
            4'h1: begin
              control_d = {3'd0, 3'd0, rd, ALU_PASS_IN};
              retired_d = retired_q + 8'd1;
            end
            4'h2: begin
              control_d = {ra, 3'd0, rd, ALU_PASS_A};
              retired_d = retired_q + 8'd1;
            end
            4'h3: begin
              control_d = {ra, rb, rd, ALU_ADD};
              retired_d = retired_q + 8'd1;
            end
            4'h4: begin
              control_d = {ra, rb, rd, ALU_SUB};
              retired_d = retired_q + 8'd1;
            end
            4'h5: begin
              control_d = {ra, rb, rd, ALU_AND};
              retired_d = retired_q + 8'd1;
            end
            4'h6: begin
              control_d = {ra, rb, rd, ALU_OR};
              retired_d = retired_q + 8'd1;
            end
            4'h7: begin
              control_d = {ra, rb, rd, ALU_XOR};
              retired_d = retired_q + 8'd1;
            end
            4'h8: begin
              control_d = {rd, 3'd0, TMP_REG, ALU_PASS_A};
              swap_rd_d = rd;
              swap_ra_d = ra;
              state_d   = SW1;
            end
            4'hF: begin
              state_d   = HALTED;
              halted_d  = 1'b1;
              retired_d = retired_q + 8'd1;
            end
            default: retired_d = retired_q + 8'd1;
          endcase
        end
      end
      SW1: begin
        control_d = {swap_ra_q, 3'd0, swap_rd_q, ALU_PASS_A};
        state_d   = SW2;
      end
      SW2: begin
        control_d = {TMP_REG, 3'd0, swap_ra_q, ALU_PASS_A};
        retired_d = retired_q + 8'd1;
        state_d   = IDLE;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers; reset aborts any SWAP in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      control_q <= 14'd0;
      halted_q  <= 1'b0;
      retired_q <= 8'd0;
      swap_rd_q <= 3'd0;
      swap_ra_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      control_q <= control_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
      swap_rd_q <= swap_rd_d;
      swap_ra_q <= swap_ra_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic error_q, error_d;

  // Sticky trap flag, cleared only by reset.
  always_comb error_d = error_q | trap;

  // Error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) error_q <= 1'b0;
    else     error_q <= error_d;
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign control = control_q;
  assign halted  = halted_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu2_control_unit.sv
// Testbench for cpu2_control_unit: directed steps followed by random
// instruction streams, compared against a queue-based reference model.
module tb_cpu2_control_unit;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [13:0] control;
  logic        halted;
  logic        error;
  logic [7:0]  retired;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [13:0] pending[$];
  logic [13:0] exp_ctrl;
  logic        m_halted;
  logic        m_error;
  logic [7:0]  m_retired;

  cpu2_control_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .control     (control),
    .halted      (halted),
    .error       (error),
    .retired     (retired)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit modelReady();
    return !m_halted && (pending.size() == 0);
  endfunction

  task automatic modelReset();
    pending.delete();
    exp_ctrl  = 14'd0;
    m_halted  = 1'b0;
    m_error   = 1'b0;
    m_retired = 8'd0;
  endtask

  task automatic modelTrap();
    m_halted = 1'b1;
    m_error  = 1'b1;
  endtask

  // One clock edge of the architectural model.
  task automatic modelEdge(input logic [15:0] ins, input bit acc);
    logic [3:0] op;
    logic [2:0] d, a, b;
    op = ins[15:12];
    d  = ins[11:9];
    a  = ins[8:6];
    b  = ins[5:3];
    exp_ctrl = 14'd0;
    if (pending.size() > 0) begin
      exp_ctrl = pending.pop_front();
      if (pending.size() == 0) m_retired = m_retired + 8'd1;
    end else if (acc) begin
      case (op)
        4'h0: m_retired = m_retired + 8'd1;
        4'h1: begin exp_ctrl = {6'd0, d, 5'd0};  m_retired = m_retired + 8'd1; end
        4'h2: begin exp_ctrl = {a, 3'd0, d, 5'd1}; m_retired = m_retired + 8'd1; end
        4'h3: begin exp_ctrl = {a, b, d, 5'd2}; m_retired = m_retired + 8'd1; end
        4'h4: begin exp_ctrl = {a, b, d, 5'd3}; m_retired = m_retired + 8'd1; end
        4'h5: begin exp_ctrl = {a, b, d, 5'd4}; m_retired = m_retired + 8'd1; end
        4'h6: begin exp_ctrl = {a, b, d, 5'd5}; m_retired = m_retired + 8'd1; end
        4'h7: begin exp_ctrl = {a, b, d, 5'd6}; m_retired = m_retired + 8'd1; end
        4'h8: begin
          if (TRAP && (d == 3'd7 || a == 3'd7)) modelTrap();
          else begin
            exp_ctrl = {d, 3'd0, 3'd7, 5'd1};
            pending.push_back({a, 3'd0, d, 5'd1});
            pending.push_back({3'd7, 3'd0, a, 5'd1});
          end
        end
        4'hF: begin m_halted = 1'b1; m_retired = m_retired + 8'd1; end
        default: begin
          if (TRAP) modelTrap();
          else m_retired = m_retired + 8'd1;
        end
      endcase
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".control"}, {2'b00, control}, {2'b00, exp_ctrl});
    checkOutput({tag, ".halted"},  {15'd0, halted},  {15'd0, m_halted});
    checkOutput({tag, ".error"},   {15'd0, error},   {15'd0, m_error});
    checkOutput({tag, ".retired"}, {8'd0, retired},  {8'd0, m_retired});
  endtask

  // Drive one instruction for one clock, then check all outputs after the edge.
  task automatic applyStimulus(input string tag, input logic [15:0] ins, input bit vld);
    bit acc;
    instr       = ins;
    instr_valid = vld;
    #1;
    checkOutput({tag, ".ready"}, {15'd0, instr_ready}, {15'd0, modelReady()});
    acc = vld && modelReady();
    @(posedge clk);
    #1;
    modelEdge(ins, acc);
    checkAll(tag);
  endtask

  // Asynchronous reset, checked before any clock edge occurs.
  task automatic doReset(input string tag);
    rst         = 1'b1;
    instr_valid = 1'b0;
    #1;
    modelReset();
    checkAll(tag);
    checkOutput({tag, ".ready"}, {15'd0, instr_ready}, 16'd1);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] ins;
    logic [31:0] rnd;
    logic [3:0]  op;
    int          r;

    rst         = 1'b1;
    instr       = 16'h0000;
    instr_valid = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkAll("reset");
    checkOutput("reset.ready", {15'd0, instr_ready}, 16'd1);
    applyStimulus("idle", 16'h1200, 1'b0);

    // Back-to-back LDI, then ADD for one cycle followed by NOP word.
    applyStimulus("ldi1", 16'h1200, 1'b1);
    applyStimulus("ldi2", 16'h1400, 1'b1);
    applyStimulus("add",  16'h3688, 1'b1);
    applyStimulus("after_add", 16'h0000, 1'b0);

    // SWAP with valid held high; ADD accepted on the fourth edge.
    applyStimulus("swap_w1", 16'h8280, 1'b1);
    applyStimulus("swap_w2", 16'h8280, 1'b1);
    applyStimulus("swap_w3", 16'h8280, 1'b1);
    applyStimulus("swap_next", 16'h3688, 1'b1);

    // Reset in the middle of a SWAP.
    applyStimulus("swap_abort", 16'h8280, 1'b1);
    doReset("rst_sw1");
    applyStimulus("post_abort", 16'h0000, 1'b0);

    // Illegal opcode, then HALT in a fresh run.
    applyStimulus("illegal", 16'hA000, 1'b1);
    applyStimulus("illegal_after", 16'h1200, 1'b1);
    doReset("rst2");
    applyStimulus("halt", 16'hF000, 1'b1);
    applyStimulus("halt_hold", 16'h1200, 1'b1);
    doReset("rst3");

    // Random instruction streams; reset whenever the model halts.
    for (int i = 0; i < 600; i++) begin
      if (m_halted) doReset("rand_rst");
      r = $urandom_range(0, 99);
      if (r < 85)      op = 4'($urandom_range(0, 8));
      else if (r < 97) op = 4'($urandom_range(9, 14));
      else             op = 4'hF;
      rnd = $urandom();
      ins = {op, rnd[11:0]};
      applyStimulus("rand", ins, ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
